// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the conv serial link receive side.
//   conv_deser_state_t : deserializer FSM states
//   CONV_START_BIT     : line level that opens a frame
//   conv_frame_len()   : total frame length in cycles for a given pair count
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } conv_deser_state_t;

    localparam logic CONV_START_BIT = 1'b1;

    // start bit + 2*num_pairs data bits + parity bit
    function automatic int conv_frame_len(input int num_pairs);
        return 2 * num_pairs + 2;
    endfunction

endpackage

// File: rtl/conv_deser_out_reg.sv
// conv_deser_out_reg: valid/ready holding register for decoded words.
//   CLK, RESET      : clock, async active-low reset
//   good_word       : a frame passed parity this cycle (completion edge)
//   word1, word2    : decoded channel words offered with good_word
//   ready           : downstream consumes the held word on this edge
//   valid           : out1/out2 hold an unconsumed word
//   out1, out2      : held words, stable while valid=1
//   overrun         : one-cycle pulse, a good word was dropped (holder full)
module conv_deser_out_reg #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         good_word,
    input  logic [W-1:0] word1,
    input  logic [W-1:0] word2,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] out1,
    output logic [W-1:0] out2,
    output logic         overrun
);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid   <= 1'b0;
            out1    <= '0;
            out2    <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (good_word) begin
                // A consume on the same edge frees the slot for the new word.
                if (!valid || ready) begin
                    out1  <= word1;
                    out2  <= word2;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                // Data keeps its last value; only the flag drops.
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/conv_deserializer.sv
// conv_deserializer: samples a framed serial stream and rebuilds two
// NUM_PAIRS-bit channels, checked with even parity.
//   CLK        : clock (rising edge)
//   RESET      : async active-low reset
//   SERIAL_IN  : serial line, idles at 0
//   PAR_OUT1/2 : channel words of the last accepted frame
//   OUT_VALID  : PAR_OUT* hold an unconsumed word
//   OUT_READY  : downstream accepts the word when OUT_VALID=1
//   PARITY_ERR : one-cycle pulse, completed frame failed parity
//   OVERRUN    : one-cycle pulse, good frame dropped because holder full
module conv_deserializer
    import conv_pkg::*;
#(
    parameter int NUM_PAIRS = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 SERIAL_IN,
    output logic [NUM_PAIRS-1:0] PAR_OUT1,
    output logic [NUM_PAIRS-1:0] PAR_OUT2,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic                 PARITY_ERR,
    output logic                 OVERRUN
);

    localparam int NBITS = conv_frame_len(NUM_PAIRS) - 2;
    localparam int CW    = (NBITS > 2) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    conv_deser_state_t    state;
    logic [CW-1:0]        cnt;
    logic                 par;
    logic [NUM_PAIRS-1:0] sr1, sr2;
    logic                 good_word;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            par        <= 1'b0;
            sr1        <= '0;
            sr2        <= '0;
            PARITY_ERR <= 1'b0;
        end else begin
            PARITY_ERR <= 1'b0;
            case (state)
                IDLE: begin
                    if (SERIAL_IN == CONV_START_BIT) begin
                        state <= DATA;
                        cnt   <= '0;
                        par   <= 1'b0;
                    end
                end
                DATA: begin
                    // LSB first: shift right so the first bit lands in bit 0.
                    if (!cnt[0]) sr1 <= {SERIAL_IN, sr1[NUM_PAIRS-1:1]};
                    else         sr2 <= {SERIAL_IN, sr2[NUM_PAIRS-1:1]};
                    par <= par ^ SERIAL_IN;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= PARITY;
                end
                PARITY: begin
                    PARITY_ERR <= (SERIAL_IN != par);
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign good_word = (state == PARITY) && (SERIAL_IN == par);

    conv_deser_out_reg #(.W(NUM_PAIRS)) u_out (
        .CLK       (CLK),
        .RESET     (RESET),
        .good_word (good_word),
        .word1     (sr1),
        .word2     (sr2),
        .ready     (OUT_READY),
        .valid     (OUT_VALID),
        .out1      (PAR_OUT1),
        .out2      (PAR_OUT2),
        .overrun   (OVERRUN)
    );

endmodule

// File: tb/tb_conv_deserializer.sv
module tb_conv_deserializer;
    localparam int N = 4;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic         SERIAL_IN = 1'b0;
    logic         OUT_READY = 1'b0;
    logic [N-1:0] PAR_OUT1, PAR_OUT2;
    logic         OUT_VALID, PARITY_ERR, OVERRUN;

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    conv_deserializer #(.NUM_PAIRS(N)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .SERIAL_IN  (SERIAL_IN),
        .PAR_OUT1   (PAR_OUT1),
        .PAR_OUT2   (PAR_OUT2),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .PARITY_ERR (PARITY_ERR),
        .OVERRUN    (OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Collects the 2N+1 bits after a start bit, then decodes the whole frame.
    bit         m_coll;
    bit         q[$];
    logic [N-1:0] m1, m2, w1, w2;
    bit         mv, mperr, movr, m_done, m_ok, p;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_coll = 0; q.delete();
            mv = 0; m1 = '0; m2 = '0; mperr = 0; movr = 0;
        end else begin
            m_done = 0; m_ok = 0; mperr = 0; movr = 0;
            if (!m_coll) begin
                if (SERIAL_IN) begin m_coll = 1; q.delete(); end
            end else begin
                q.push_back(SERIAL_IN);
                if (q.size() == 2*N+1) begin
                    m_coll = 0; m_done = 1; p = 0;
                    for (int i = 0; i < 2*N; i++) p ^= q[i];
                    m_ok = (p == q[2*N]);
                    for (int k = 0; k < N; k++) begin
                        w1[k] = q[2*k];
                        w2[k] = q[2*k+1];
                    end
                end
            end
            if (m_done && !m_ok) mperr = 1;
            if (m_done && m_ok) begin
                if (!mv || OUT_READY) begin m1 = w1; m2 = w2; mv = 1; end
                else movr = 1;
            end else if (mv && OUT_READY) mv = 0;
        end
    end

    always @(negedge CLK) begin
        if (cmp_on) begin
            chk("cyc_valid", {31'd0, OUT_VALID}, {31'd0, mv});
            chk("cyc_out1", {28'd0, PAR_OUT1}, {28'd0, m1});
            chk("cyc_out2", {28'd0, PAR_OUT2}, {28'd0, m2});
            chk("cyc_perr", {31'd0, PARITY_ERR}, {31'd0, mperr});
            chk("cyc_ovr", {31'd0, OVERRUN}, {31'd0, movr});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input logic b, input logic rdy);
        @(negedge CLK);
        SERIAL_IN = b;
        OUT_READY = rdy;
    endtask

    // Drives one frame; rdy for all bits except the parity bit, which uses rdy_last.
    task automatic send_frame(input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic flip, input logic rdy, input logic rdy_last);
        logic pp;
        pp = (^a) ^ (^b) ^ flip;
        tick(1'b1, rdy);
        for (int k = 0; k < N; k++) begin
            tick(a[k], rdy);
            tick(b[k], rdy);
        end
        tick(pp, rdy_last);
    endtask

    task automatic after_edge();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [9:0] bits1;
        // reset state
        #12;
        chk("rst_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("rst_out1", {28'd0, PAR_OUT1}, 32'd0);
        chk("rst_flags", {30'd0, PARITY_ERR, OVERRUN}, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        cmp_on = 1'b1;

        // 1. basic decode, raw bit vector
        bits1 = 10'b1001101100;   // sent MSB of this vector first
        for (int i = 9; i >= 0; i--) tick(bits1[i], 1'b0);
        after_edge();
        chk("t1_valid", {31'd0, OUT_VALID}, 32'd1);
        chk("t1_out1", {28'd0, PAR_OUT1}, 32'b1010);
        chk("t1_out2", {28'd0, PAR_OUT2}, 32'b0110);
        chk("t1_perr", {31'd0, PARITY_ERR}, 32'd0);
        tick(1'b0, 1'b1);
        after_edge();
        chk("t1_consumed", {31'd0, OUT_VALID}, 32'd0);
        tick(1'b0, 1'b0);

        // 2. same frame, parity bit flipped to 1
        for (int i = 9; i >= 1; i--) tick(bits1[i], 1'b0);
        tick(1'b1, 1'b0);
        after_edge();
        chk("t2_perr", {31'd0, PARITY_ERR}, 32'd1);
        chk("t2_valid", {31'd0, OUT_VALID}, 32'd0);
        tick(1'b0, 1'b0);
        after_edge();
        chk("t2_perr_gone", {31'd0, PARITY_ERR}, 32'd0);

        // 3. back-to-back, consume exactly at B's completion edge
        send_frame(4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
        after_edge();
        chk("t3_a_out1", {28'd0, PAR_OUT1}, 32'hF);
        chk("t3_a_out2", {28'd0, PAR_OUT2}, 32'h0);
        send_frame(4'h3, 4'hC, 1'b0, 1'b0, 1'b1);
        after_edge();
        chk("t3_b_out1", {28'd0, PAR_OUT1}, 32'h3);
        chk("t3_b_out2", {28'd0, PAR_OUT2}, 32'hC);
        chk("t3_b_valid", {31'd0, OUT_VALID}, 32'd1);
        chk("t3_no_ovr", {31'd0, OVERRUN}, 32'd0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);

        // 4. overrun
        send_frame(4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
        send_frame(4'h3, 4'hC, 1'b0, 1'b0, 1'b0);
        after_edge();
        chk("t4_ovr", {31'd0, OVERRUN}, 32'd1);
        chk("t4_out1", {28'd0, PAR_OUT1}, 32'hF);
        chk("t4_out2", {28'd0, PAR_OUT2}, 32'h0);
        chk("t4_valid", {31'd0, OUT_VALID}, 32'd1);
        tick(1'b0, 1'b0);
        after_edge();
        chk("t4_ovr_gone", {31'd0, OVERRUN}, 32'd0);

        // 5. reset during data bit 3 (frame ch1=3, ch2=0; tail bits all 0)
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        #2;
        RESET = 1'b0;
        #1;
        chk("t5_async_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("t5_async_out1", {28'd0, PAR_OUT1}, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        SERIAL_IN = 1'b0;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
        after_edge();
        chk("t5_no_valid", {31'd0, OUT_VALID}, 32'd0);
        send_frame(4'h5, 4'hA, 1'b0, 1'b0, 1'b0);
        after_edge();
        chk("t5_out1", {28'd0, PAR_OUT1}, 32'h5);
        chk("t5_out2", {28'd0, PAR_OUT2}, 32'hA);
        chk("t5_valid", {31'd0, OUT_VALID}, 32'd1);

        // 6. idle line after consuming the held word
        tick(1'b0, 1'b1);
        for (int i = 0; i < 50; i++) begin
            tick(1'b0, 1'b0);
            after_edge();
            chk("t6_idle", {29'd0, OUT_VALID, PARITY_ERR, OVERRUN}, 32'd0);
        end

        @(negedge CLK);
        cmp_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
